// File: rtl/mux4x1_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4x1_pkg
// Description : Shared types and constants for the 4-requester round-robin
//               arbiter that drives the select lines of a 4:1 mux.
// Contents    : NUM_REQ, CNT_W, idx_t (requester index), state_t (FSM).
// Revision    : 1.0 - initial release
// ============================================================================
package mux4x1_pkg;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : mux4x1_pkg
`default_nettype wire

// File: rtl/mux4x1_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux4x1_rr_arbiter_if
// Description : Request/grant bundle between the requesters, the downstream
//               consumer and the round-robin arbiter.
// Signals     : req[3:0]  - one request per mux input
//               ready     - downstream accepts y this cycle
//               gnt[3:0]  - one-hot grant (zero when idle)
//               s0, s1    - mux select LSB / MSB
//               valid     - y carries the owner's data this cycle
// Modports    : master (requester/consumer side), slave (arbiter side)
// Revision    : 1.0 - initial release
// ============================================================================
interface mux4x1_rr_arbiter_if;
  import mux4x1_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               ready;
  logic [NUM_REQ-1:0] gnt;
  logic               s0;
  logic               s1;
  logic               valid;

  modport master (
    output req,
    output ready,
    input  gnt,
    input  s0,
    input  s1,
    input  valid
  );

  modport slave (
    input  req,
    input  ready,
    output gnt,
    output s0,
    output s1,
    output valid
  );

endinterface : mux4x1_rr_arbiter_if
`default_nettype wire

// File: rtl/mux4x1.sv
`default_nettype none
// ============================================================================
// Module      : mux4x1
// Description : Plain 4:1 multiplexer, y = i[{s1,s0}].
// Ports       : i0..i3 (in), s0/s1 (in, select LSB/MSB), y (out)
// Revision    : 1.0 - initial release
// ============================================================================
module mux4x1 (
  input  wire logic i0,
  input  wire logic i1,
  input  wire logic i2,
  input  wire logic i3,
  input  wire logic s0,
  input  wire logic s1,
  output logic      y
);

  always_comb begin
    y = i0;
    case ({s1, s0})
      2'd0:    y = i0;
      2'd1:    y = i1;
      2'd2:    y = i2;
      default: y = i3;
    endcase
  end

endmodule : mux4x1
`default_nettype wire

// File: rtl/mux4x1_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotating priority encoder. Returns the first
//               set bit of req scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
// Ports       : req[3:0] (in), ptr[1:0] (in, last granted index),
//               idx[1:0] (out, chosen index), found (out, req != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import mux4x1_pkg::*;
(
  input  wire logic [NUM_REQ-1:0] req,
  input  wire idx_t               ptr,
  output idx_t                    idx,
  output logic                    found
);

  idx_t w_cand;

  // Scan from the farthest candidate to the nearest so the nearest set bit
  // after ptr is the last (winning) assignment.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_cand = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = ptr + idx_t'(i);
      if (req[w_cand]) begin
        idx   = w_cand;
        found = 1'b1;
      end
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4x1_rr_arbiter
// Description : Round-robin arbiter sharing a 4:1 mux among four requesters.
//               A grant is held until the owner drops req or completes
//               MAX_HOLD accepted beats; handover re-picks in the same edge
//               so there is no idle bubble between owners.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous reset, active-high
//               bus  - mux4x1_rr_arbiter_if.slave (req, ready, gnt, s0, s1,
//                      valid)
// Parameters  : MAX_HOLD - accepted beats per tenure, 1..15
// Revision    : 1.0 - initial release
// ============================================================================
module mux4x1_rr_arbiter
  import mux4x1_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mux4x1_rr_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(MAX_HOLD - 1);

  state_t           r_state, w_state_nxt;
  idx_t             r_owner, w_owner_nxt;
  idx_t             r_ptr,   w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

  logic             w_valid;
  logic             w_beat;
  logic             w_release;
  idx_t             w_pick_ptr;
  idx_t             w_pick_idx;
  logic             w_found;
  logic [NUM_REQ-1:0] w_gnt;

  assign w_valid   = (r_state == GRANT) && bus.req[r_owner];
  assign w_beat    = w_valid && bus.ready;
  assign w_release = (r_state == GRANT) &&
                     (!bus.req[r_owner] || (w_beat && (r_cnt == c_LAST_BEAT)));

  // On release the pointer moves to the outgoing owner in the same edge, so
  // the re-pick must already see the updated pointer.
  assign w_pick_ptr = w_release ? r_owner : r_ptr;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (w_pick_ptr),
    .idx   (w_pick_idx),
    .found (w_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_owner;
          w_cnt_nxt = '0;
          if (w_found) begin
            // Includes a sole requester re-granted to itself at the limit.
            w_owner_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt = '0;
    if (r_state == GRANT) begin
      w_gnt[r_owner] = 1'b1;
    end
  end

  // Select follows the owner register, so it holds the last owner in IDLE.
  assign bus.gnt   = w_gnt;
  assign bus.s0    = r_owner[0];
  assign bus.s1    = r_owner[1];
  assign bus.valid = w_valid;

endmodule : mux4x1_rr_arbiter
`default_nettype wire

// File: tb/tb_mux4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4x1_rr_arbiter
// Description : Self-checking bench for mux4x1_rr_arbiter. Two arbiters
//               (MAX_HOLD=4 and MAX_HOLD=1) share the same request/ready
//               stimulus; a mux4x1 is wired to the first one's selects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4x1_rr_arbiter;

  logic       clk = 1'b0;
  logic       t_rst = 1'b1;
  logic [3:0] t_req = 4'hF;
  logic       t_rdy = 1'b1;
  logic [3:0] t_i   = 4'b0101;   // i0=1, i1=0, i2=1, i3=0
  logic       y;

  int errors   = 0;
  int n_checks = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  mux4x1_rr_arbiter_if bus0 ();
  mux4x1_rr_arbiter_if bus1 ();

  assign bus0.req   = t_req;
  assign bus0.ready = t_rdy;
  assign bus1.req   = t_req;
  assign bus1.ready = t_rdy;

  mux4x1_rr_arbiter #(.MAX_HOLD(4)) u_dut0 (.clk(clk), .rst(t_rst), .bus(bus0));
  mux4x1_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst(t_rst), .bus(bus1));

  mux4x1 u_mux (
    .i0(t_i[0]), .i1(t_i[1]), .i2(t_i[2]), .i3(t_i[3]),
    .s0(bus0.s0), .s1(bus0.s1), .y(y)
  );

  // ------------------------------------------------------------------------
  // Reference model: tracks who holds the mux, the last granted index and
  // the beats taken so far, straight from the arbitration rules.
  // ------------------------------------------------------------------------
  int  m_hold [2] = '{4, 1};
  bit  m_busy [2] = '{0, 0};
  int  m_own  [2] = '{0, 0};
  int  m_ptr  [2] = '{3, 3};
  int  m_cnt  [2] = '{0, 0};

  function automatic int pick_next(input logic [3:0] r, input int last);
    for (int d = 1; d <= 4; d++) begin
      if (r[(last + d) % 4]) return (last + d) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (t_rst) begin
        m_busy[j] = 0; m_own[j] = 0; m_ptr[j] = 3; m_cnt[j] = 0;
      end else if (m_busy[j]) begin
        bit v, beat, done;
        int p;
        v    = t_req[m_own[j]];
        beat = v && t_rdy;
        if (beat) m_cnt[j] = m_cnt[j] + 1;
        done = !v || (beat && m_cnt[j] == m_hold[j]);
        if (done) begin
          m_ptr[j] = m_own[j];
          m_cnt[j] = 0;
          p = pick_next(t_req, m_ptr[j]);
          if (p >= 0) m_own[j] = p;
          else        m_busy[j] = 0;
        end
      end else begin
        int p;
        p = pick_next(t_req, m_ptr[j]);
        if (p >= 0) begin
          m_busy[j] = 1; m_own[j] = p; m_cnt[j] = 0;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs away from the active edge, then let outputs settle.
  task automatic cyc(input bit r, input logic [3:0] rq, input bit rd);
    @(negedge clk);
    t_rst = r; t_req = rq; t_rdy = rd;
    #1;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    bit         rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    bit         valid;
    bit         y;
    logic [3:0] gnt1;
  } vec_t;

  vec_t tbl [23];

  initial begin
    int o;
    int waited;
    bit seen;
    bit pat [6] = '{1, 0, 0, 1, 1, 1};

    // Reset / full-load rotation table (MAX_HOLD=4 on dut0, 1 on dut1).
    for (int k = 0; k < 23; k++) begin
      tbl[k].rst = (k < 2);
      tbl[k].req = 4'hF;
      tbl[k].rdy = 1'b1;
      if (k < 3) begin
        tbl[k].gnt = 4'h0; tbl[k].sel = 2'd0; tbl[k].valid = 1'b0;
        tbl[k].y = 1'b1;   tbl[k].gnt1 = 4'h0;
      end else begin
        o = ((k - 3) / 4) % 4;
        tbl[k].gnt   = 4'(1 << o);
        tbl[k].sel   = 2'(o);
        tbl[k].valid = 1'b1;
        tbl[k].y     = (o % 2 == 0);
        tbl[k].gnt1  = 4'(1 << ((k - 3) % 4));
      end
    end

    @(posedge clk);   // one reset edge before the table starts
    for (int k = 0; k < 23; k++) begin
      cyc(tbl[k].rst, tbl[k].req, tbl[k].rdy);
      chk($sformatf("tbl[%0d].gnt", k),   {4'h0, bus0.gnt},         {4'h0, tbl[k].gnt});
      chk($sformatf("tbl[%0d].sel", k),   {6'h0, bus0.s1, bus0.s0}, {6'h0, tbl[k].sel});
      chk($sformatf("tbl[%0d].valid", k), {7'h0, bus0.valid},       {7'h0, tbl[k].valid});
      chk($sformatf("tbl[%0d].y", k),     {7'h0, y},                {7'h0, tbl[k].y});
      chk($sformatf("tbl[%0d].gnt_h1", k),{4'h0, bus1.gnt},         {4'h0, tbl[k].gnt1});
    end

    // Sole requester 2: grant held continuously across hold-limit expiries.
    cyc(1, 4'h4, 1);
    cyc(0, 4'h4, 1);
    chk("sole.idle", {4'h0, bus0.gnt}, 8'h00);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 4'h4, 1);
      chk("sole.gnt",    {4'h0, bus0.gnt}, 8'h04);
      chk("sole.valid",  {7'h0, bus0.valid}, 8'h01);
      chk("sole.gnt_h1", {4'h0, bus1.gnt}, 8'h04);
    end

    // Owner 1, ready 1,0,0,1,1,1: release after 4th accepted beat, then 0.
    cyc(1, 4'h2, 0);
    cyc(0, 4'h2, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 4'h3, pat[k]);
      chk("stall.gnt", {4'h0, bus0.gnt}, 8'h02);
    end
    cyc(0, 4'h3, 1);
    chk("stall.next", {4'h0, bus0.gnt}, 8'h01);

    // Owner 0 drops after 2 beats while 3 waits: handover to 3.
    cyc(1, 4'h9, 1);
    cyc(0, 4'h9, 1);
    cyc(0, 4'h9, 1);
    chk("drop.own0", {4'h0, bus0.gnt}, 8'h01);
    cyc(0, 4'h9, 1);
    cyc(0, 4'h8, 1);
    chk("drop.novalid", {7'h0, bus0.valid}, 8'h00);
    cyc(0, 4'h8, 1);
    chk("drop.gnt", {4'h0, bus0.gnt}, 8'h08);
    chk("drop.sel", {6'h0, bus0.s1, bus0.s0}, 8'h03);

    // Reset during owner 2's tenure.
    cyc(1, 4'hF, 1);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 30) begin
      cyc(0, 4'hF, 1);
      seen = (bus0.gnt == 4'h4);
      waited++;
    end
    chk("rstmid.reach2", {7'h0, seen}, 8'h01);
    cyc(1, 4'hF, 1);
    cyc(0, 4'hF, 1);
    chk("rstmid.gnt0", {4'h0, bus0.gnt}, 8'h00);
    cyc(0, 4'hF, 1);
    chk("rstmid.first", {4'h0, bus0.gnt}, 8'h01);

    // Randomized traffic against the reference model, both hold limits.
    cyc(1, 4'h0, 0);
    model_on = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic [3:0] rq;
      rq = t_req;
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 63) == 0), rq, 1'($urandom_range(0, 1)));
      for (int j = 0; j < 2; j++) begin
        logic [3:0] eg;
        logic [1:0] es;
        bit ev;
        eg = m_busy[j] ? 4'(1 << m_own[j]) : 4'h0;
        es = 2'(m_own[j]);
        ev = m_busy[j] && t_req[m_own[j]];
        if (j == 0) begin
          chk("rnd.gnt",   {4'h0, bus0.gnt},         {4'h0, eg});
          chk("rnd.sel",   {6'h0, bus0.s1, bus0.s0}, {6'h0, es});
          chk("rnd.valid", {7'h0, bus0.valid},       {7'h0, ev});
        end else begin
          chk("rnd.gnt_h1",   {4'h0, bus1.gnt},         {4'h0, eg});
          chk("rnd.sel_h1",   {6'h0, bus1.s1, bus1.s0}, {6'h0, es});
          chk("rnd.valid_h1", {7'h0, bus1.valid},       {7'h0, ev});
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule : tb_mux4x1_rr_arbiter
`default_nettype wire
